// File: rtl/vga_timing_gen_pkg.sv
// Shared mode constants, pipeline flag bundle and region decode for the
// VGA raster engine.
package vga_timing_pkg;

  // 800x600@72 Hz, 50 MHz pixel clock, positive syncs
  localparam int unsigned M800_H_ACTIVE = 800;
  localparam int unsigned M800_H_FP     = 56;
  localparam int unsigned M800_H_SYNC   = 120;
  localparam int unsigned M800_H_BP     = 64;
  localparam int unsigned M800_V_ACTIVE = 600;
  localparam int unsigned M800_V_FP     = 37;
  localparam int unsigned M800_V_SYNC   = 6;
  localparam int unsigned M800_V_BP     = 23;
  localparam bit          M800_HS_POL   = 1'b1;
  localparam bit          M800_VS_POL   = 1'b1;

  // 640x480@60 Hz, 800x525 total, negative syncs
  localparam int unsigned M640_H_ACTIVE = 640;
  localparam int unsigned M640_H_FP     = 16;
  localparam int unsigned M640_H_SYNC   = 96;
  localparam int unsigned M640_H_BP     = 48;
  localparam int unsigned M640_V_ACTIVE = 480;
  localparam int unsigned M640_V_FP     = 10;
  localparam int unsigned M640_V_SYNC   = 2;
  localparam int unsigned M640_V_BP     = 33;
  localparam bit          M640_HS_POL   = 1'b0;
  localparam bit          M640_VS_POL   = 1'b0;

  // Flags carried alongside a pixel from request to the output pins
  typedef struct packed {
    logic de;
    logic hsa;
    logic vsa;
    logic fs;
    logic ls;
  } pipe_t;

  // True when pos lies in [lo, lo+len)
  function automatic logic in_region(input int unsigned pos,
                                     input int unsigned lo,
                                     input int unsigned len);
    return (pos >= lo) && (pos < lo + len);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel request/response bus between the raster engine and its pixel source.
interface vga_timing_gen_if #(
  parameter int unsigned CW = 4,
  parameter int unsigned XW = 12,
  parameter int unsigned YW = 11
);
  logic          req;
  logic [XW-1:0] req_x;
  logic [YW-1:0] req_y;
  logic [CW-1:0] pixR;
  logic [CW-1:0] pixG;
  logic [CW-1:0] pixB;
  logic          pix_valid;

  modport master (output req, req_x, req_y,
                  input  pixR, pixG, pixB, pix_valid);
  modport slave  (input  req, req_x, req_y,
                  output pixR, pixG, pixB, pix_valid);
endinterface

// File: rtl/vga_timing_gen_axis.sv
// One raster axis: position counter with active/sync region decode.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned W      = 12,
  parameter int unsigned ACTIVE = 800,
  parameter int unsigned FP     = 56,
  parameter int unsigned SYNC   = 120,
  parameter int unsigned BP     = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         active,
  output logic         sync
);
  localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;

  logic [W-1:0] r_count;

  // Advance on inc, returning to 0 after the last position of the axis
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   r_count <= '0;
    else if (inc) r_count <= wrap ? '0 : r_count + 1'b1;
  end

  assign count  = r_count;
  assign wrap   = (r_count == W'(TOTAL - 1));
  assign active = in_region(32'(r_count), 32'd0, ACTIVE);
  assign sync   = in_region(32'(r_count), ACTIVE + FP, SYNC);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster engine: counters, pixel requests ahead of a fixed-latency
// source, colour/sync realignment and sticky underflow detection.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CW       = 4,
  parameter int unsigned XW       = 12,
  parameter int unsigned YW       = 11,
  parameter int unsigned H_ACTIVE = M800_H_ACTIVE,
  parameter int unsigned H_FP     = M800_H_FP,
  parameter int unsigned H_SYNC   = M800_H_SYNC,
  parameter int unsigned H_BP     = M800_H_BP,
  parameter int unsigned V_ACTIVE = M800_V_ACTIVE,
  parameter int unsigned V_FP     = M800_V_FP,
  parameter int unsigned V_SYNC   = M800_V_SYNC,
  parameter int unsigned V_BP     = M800_V_BP,
  parameter bit          HS_POL   = M800_HS_POL,
  parameter bit          VS_POL   = M800_VS_POL,
  parameter int unsigned LAT      = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  vga_timing_gen_if.master     pix,
  input  logic                 underflow_clr,
  output logic [CW-1:0]        VGA_R,
  output logic [CW-1:0]        VGA_G,
  output logic [CW-1:0]        VGA_B,
  output logic                 VGA_HS,
  output logic                 VGA_VS,
  output logic                 frame_start,
  output logic                 line_start,
  output logic                 underflow
);

  logic [XW-1:0] w_h;
  logic [YW-1:0] w_v;
  logic          w_h_wrap, w_v_wrap;
  logic          w_hact, w_vact, w_hsync, w_vsync;
  logic          r_origin, r_line, r_en_frame, w_en_frame, w_de;
  pipe_t         w_s0, w_d;

  logic [CW-1:0] r_r, r_g, r_b;
  logic          r_hs, r_vs, r_fs, r_ls, r_uf;

  vga_axis_counter #(
    .W(XW), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h (
    .clk(clk), .reset(reset), .inc(1'b1),
    .count(w_h), .wrap(w_h_wrap), .active(w_hact), .sync(w_hsync)
  );

  vga_axis_counter #(
    .W(YW), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v (
    .clk(clk), .reset(reset), .inc(w_h_wrap),
    .count(w_v), .wrap(w_v_wrap), .active(w_vact), .sync(w_vsync)
  );

  // Origin and column-0 markers are registered from the wrap flags one cycle
  // early (reset value 1) instead of comparing both counters against zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_origin <= 1'b1;
      r_line   <= 1'b1;
    end else begin
      r_origin <= w_h_wrap & w_v_wrap;
      r_line   <= w_h_wrap;
    end
  end

  // At the frame origin en passes straight through so req follows it at once
  assign w_en_frame = r_origin ? en : r_en_frame;

  // Hold the frame enable for the rest of the frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_en_frame <= 1'b0;
    else        r_en_frame <= w_en_frame;
  end

  assign w_de      = w_en_frame & w_hact & w_vact;
  assign pix.req   = reset & w_de;
  assign pix.req_x = w_h;
  assign pix.req_y = w_v;

  assign w_s0 = '{de: w_de, hsa: w_hsync, vsa: w_vsync, fs: r_origin, ls: r_line};

  generate
    if (LAT == 0) begin : g_nodly
      assign w_d = w_s0;
    end else begin : g_dly
      pipe_t r_sr [LAT];

      // Delay the stage-0 flags by the pixel source latency
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int unsigned i = 0; i < LAT; i++) r_sr[i] <= '0;
        end else begin
          r_sr[0] <= w_s0;
          for (int unsigned i = 1; i < LAT; i++) r_sr[i] <= r_sr[i-1];
        end
      end

      assign w_d = r_sr[LAT-1];
    end
  endgenerate

  // Output register: colour gated by display enable, syncs, markers, underflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_r  <= '0;
      r_g  <= '0;
      r_b  <= '0;
      r_hs <= ~HS_POL;
      r_vs <= ~VS_POL;
      r_fs <= 1'b0;
      r_ls <= 1'b0;
      r_uf <= 1'b0;
    end else begin
      if (w_d.de && pix.pix_valid) begin
        r_r <= pix.pixR;
        r_g <= pix.pixG;
        r_b <= pix.pixB;
      end else begin
        r_r <= '0;
        r_g <= '0;
        r_b <= '0;
      end
      r_hs <= w_d.hsa ? HS_POL : ~HS_POL;
      r_vs <= w_d.vsa ? VS_POL : ~VS_POL;
      r_fs <= w_d.fs;
      r_ls <= w_d.ls;
      if (w_d.de && !pix.pix_valid) r_uf <= 1'b1;
      else if (underflow_clr)       r_uf <= 1'b0;
    end
  end

  assign VGA_R       = r_r;
  assign VGA_G       = r_g;
  assign VGA_B       = r_b;
  assign VGA_HS      = r_hs;
  assign VGA_VS      = r_vs;
  assign frame_start = r_fs;
  assign line_start  = r_ls;
  assign underflow   = r_uf;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen in a 14x7 test mode with a latency-2
// pixel source and a per-cycle expected-output queue.
module tb_vga_timing_gen;

  localparam int unsigned HA = 8, HF = 2, HSY = 2, HB = 2, HT = 14;
  localparam int unsigned VA = 4, VF = 1, VSY = 1, VB = 1, VT = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       underflow_clr = 1'b0;
  logic [3:0] VGA_R, VGA_G, VGA_B;
  logic       VGA_HS, VGA_VS, frame_start, line_start, underflow;

  vga_timing_gen_if #(.CW(4), .XW(12), .YW(11)) pix_if ();

  vga_timing_gen #(
    .CW(4), .XW(12), .YW(11),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .LAT(2)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .pix(pix_if),
    .underflow_clr(underflow_clr),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .frame_start(frame_start), .line_start(line_start), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] r, g, b;
    logic hs, vs, fs, ls, drop;
  } exp_t;

  typedef struct packed {
    logic req;
    logic [3:0] x, y;
    logic valid;
  } src_t;

  exp_t        exp_q[$];
  src_t        src_q[$];
  int unsigned hm, vm, tick_no;
  logic        enf, m_uf, clr_last, drop_arm, counting;
  int unsigned drop_x, drop_y;
  int unsigned n_vec = 0, n_err = 0;
  int unsigned hs_cnt, vs_cnt, fs_cnt, ls_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_r", 32'(VGA_R), 0);
    check("rst_g", 32'(VGA_G), 0);
    check("rst_b", 32'(VGA_B), 0);
    check("rst_hs", 32'(VGA_HS), 0);
    check("rst_vs", 32'(VGA_VS), 0);
    check("rst_req", 32'(pix_if.req), 0);
    check("rst_fs", 32'(frame_start), 0);
    check("rst_ls", 32'(line_start), 0);
    check("rst_uf", 32'(underflow), 0);
  endtask

  task automatic reset_model();
    exp_q.delete();
    src_q.delete();
    repeat (3) exp_q.push_back('0);
    repeat (2) src_q.push_back('0);
    hm = 0; vm = 0; enf = 1'b0; m_uf = 1'b0; clr_last = 1'b0;
    drop_arm = 1'b0; tick_no = 0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  // One pixel-clock cycle: drive inputs, check outputs/request, model the
  // raster position and act as the latency-2 pixel source.
  task automatic tick(input logic en_v, input logic clr_v);
    exp_t e;
    src_t s, so;
    logic de_m, valid;
    @(negedge clk);
    en = en_v;
    underflow_clr = clr_v;
    #1;
    e = exp_q.pop_front();
    m_uf = e.drop ? 1'b1 : (clr_last ? 1'b0 : m_uf);
    check("vga_r", 32'(VGA_R), 32'(e.r));
    check("vga_g", 32'(VGA_G), 32'(e.g));
    check("vga_b", 32'(VGA_B), 32'(e.b));
    check("vga_hs", 32'(VGA_HS), 32'(e.hs));
    check("vga_vs", 32'(VGA_VS), 32'(e.vs));
    check("frame_start", 32'(frame_start), 32'(e.fs));
    check("line_start", 32'(line_start), 32'(e.ls));
    check("underflow", 32'(underflow), 32'(m_uf));
    clr_last = clr_v;
    if (counting && tick_no >= 3 && tick_no < 297) begin
      hs_cnt += 32'(VGA_HS);
      vs_cnt += 32'(VGA_VS);
      fs_cnt += 32'(frame_start);
      ls_cnt += 32'(line_start);
    end

    if (hm == 0 && vm == 0) enf = en_v;
    de_m = enf && (hm < HA) && (vm < VA);
    check("req", 32'(pix_if.req), 32'(de_m));
    if (de_m) begin
      check("req_x", 32'(pix_if.req_x), hm);
      check("req_y", 32'(pix_if.req_y), vm);
    end
    valid = 1'b1;
    if (de_m && drop_arm && hm == drop_x && vm == drop_y) begin
      valid = 1'b0;
      drop_arm = 1'b0;
    end
    s = '{req: de_m, x: hm[3:0], y: vm[3:0], valid: valid};
    e = '{r:  (de_m && valid) ? hm[3:0] : 4'd0,
          g:  (de_m && valid) ? vm[3:0] : 4'd0,
          b:  (de_m && valid) ? (hm[3:0] ^ vm[3:0]) : 4'd0,
          hs: (hm >= HA + HF) && (hm < HA + HF + HSY),
          vs: (vm >= VA + VF) && (vm < VA + VF + VSY),
          fs: (hm == 0) && (vm == 0),
          ls: (hm == 0),
          drop: de_m && !valid};
    exp_q.push_back(e);

    src_q.push_back(s);
    so = src_q.pop_front();
    if (so.req) begin
      pix_if.pixR = so.x;
      pix_if.pixG = so.y;
      pix_if.pixB = so.x ^ so.y;
      pix_if.pix_valid = so.valid;
    end else begin
      pix_if.pixR = 4'($urandom);
      pix_if.pixG = 4'($urandom);
      pix_if.pixB = 4'($urandom);
      pix_if.pix_valid = 1'($urandom);
    end

    hm++;
    if (hm == HT) begin
      hm = 0;
      vm = (vm == VT - 1) ? 0 : vm + 1;
    end
    tick_no++;
  endtask

  task automatic run_to(input int unsigned h, input int unsigned v, input logic en_v);
    while (!(hm == h && vm == v)) tick(en_v, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pix_if.pixR = '0; pix_if.pixG = '0; pix_if.pixB = '0; pix_if.pix_valid = 1'b0;
    counting = 1'b0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0; ls_cnt = 0;
    drop_x = 0; drop_y = 0;
    reset = 1'b0;
    en = 1'b1;
    repeat (3) @(negedge clk);
    #1 check_reset_vals();

    // Three free-running frames with display enabled
    reset_model();
    release_reset();
    counting = 1'b1;
    repeat (297) tick(1'b1, 1'b0);
    counting = 1'b0;
    check("hs_cycles_3frames", hs_cnt, 42);
    check("vs_cycles_3frames", vs_cnt, 42);
    check("frame_starts_3frames", fs_cnt, 3);
    check("line_starts_3frames", ls_cnt, 21);

    // Single dropped pixel sets sticky underflow
    run_to(3, 2, 1'b1);
    drop_x = 3; drop_y = 2; drop_arm = 1'b1;
    run_to(0, 3, 1'b1);
    check("uf_after_drop", 32'(underflow), 1);

    // Clear coinciding with a new drop: set wins
    run_to(0, 1, 1'b1);
    drop_x = 4; drop_y = 1; drop_arm = 1'b1;
    run_to(6, 1, 1'b1);
    tick(1'b1, 1'b1);
    run_to(0, 2, 1'b1);
    check("uf_clr_vs_set", 32'(underflow), 1);

    // Clear alone
    tick(1'b1, 1'b1);
    run_to(0, 3, 1'b1);
    check("uf_cleared", 32'(underflow), 0);

    // Drop en mid-frame, then re-assert mid-frame
    run_to(0, 2, 1'b1);
    run_to(0, 0, 1'b0);
    tick(1'b0, 1'b0);
    run_to(3, 3, 1'b0);
    run_to(0, 0, 1'b1);
    run_to(5, 3, 1'b1);

    // Asynchronous reset in the middle of a line
    tick(1'b1, 1'b0);
    reset = 1'b0;
    #1 check_reset_vals();
    repeat (2) @(negedge clk);
    #1 check_reset_vals();
    reset_model();
    release_reset();
    repeat (110) tick(1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster engine: generates horizontal/vertical sync and blanking for any mode described by its porch/sync parameters. It issues pixel requests (x, y) a fixed number of cycles ahead to a pixel source with known latency, and re-aligns the returned colour with the delayed sync. It sits between the frame/pattern source and the DAC pins, replacing the fixed 800x600@72 Hz generator, and adds coordinate output, sync polarity, frame-boundary enable and underflow detection.

## Interface
- CW, 4, colour channel width
- XW, 12, horizontal counter / req_x width; H total must be ≤ 2^XW
- YW, 11, vertical counter / req_y width; V total must be ≤ 2^YW
- H_ACTIVE, H_FP, H_SYNC, H_BP, 800/56/120/64, horizontal region lengths in pixels (total HT = 1040)
- V_ACTIVE, V_FP, V_SYNC, V_BP, 600/37/6/23, vertical region lengths in lines (total VT = 666)
- HS_POL, VS_POL, 1/1, active level of VGA_HS / VGA_VS
- LAT, 2, pixel source latency in cycles, range 0..4

- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- en  in  1  display enable, sampled at frame boundary
- req  out  1  pixel request for (req_x, req_y)
- req_x  out  XW  requested column
- req_y  out  YW  requested row
- pixR, pixG, pixB  in  CW each  colour returned exactly LAT cycles after req
- pix_valid  in  1  qualifies pixR/G/B in the same cycle
- underflow_clr  in  1  clears underflow
- VGA_R, VGA_G, VGA_B  out  CW each  registered colour, 0 outside the active area
- VGA_HS, VGA_VS  out  1  registered syncs
- frame_start  out  1  one-cycle pulse aligned with output pixel (0,0)
- line_start  out  1  one-cycle pulse aligned with output column 0 of every line, including blank lines
- underflow  out  1  sticky: active output pixel had no valid data

## Operation
- Counters: h in 0..HT-1 increments every cycle. At h = HT-1, h goes to 0 and v goes to (v = VT-1) ? 0 : v+1.
- Stage-0 decode from (h, v):
  - hact = h < H_ACTIVE
  - hsa = H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC
  - vact and vsa decode the same way on v.
- en_frame is latched from en when h = 0 and v = 0. It holds for the whole frame, so a toggle of en mid-frame never tears a frame.
- req = en_frame & hact & vact; req_x = h, req_y = v. req_x/req_y are driven every cycle; they are meaningful only while req is high.
- de, hsa, vsa and the start flags are delayed LAT cycles through a shift register, then registered at the output together with the colour.
- Colour:
  - de_d & pix_valid: output pix*.
  - de_d & ~pix_valid: output 0 and set underflow.
  - ~de_d: output 0, and pix* is ignored.
- Syncs: VGA_HS = hsa_d ? HS_POL : ~HS_POL; VS the same with VS_POL. Syncs run regardless of en, so the monitor stays locked while blanked.
- underflow: set has priority over underflow_clr when both occur in the same cycle.

## Timing
- Latency: counter state (h, v) appears on the VGA pins LAT+1 cycles later; req leads its pixel by the same amount.
- Reset values:
  - counters 0, pipeline flushed
  - VGA_R/G/B 0
  - VGA_HS = ~HS_POL, VGA_VS = ~VS_POL
  - req, frame_start, line_start, underflow 0
  - en_frame 0
- First cycle after reset release: h = v = 0. en_frame loads from en in that cycle, and req follows en in the same cycle.
- Reset asserted mid-line: outputs go to reset values immediately (asynchronous). Restart always begins at (0,0); no partial line.
- Line period HT cycles; frame period HT·VT cycles; HS active H_SYNC cycles per line; VS active V_SYNC·HT cycles per frame.

## Structure
- Package vga_timing_pkg holds:
  - mode constant sets for 800x600@72 (50 MHz, defaults above) and 640x480@60 (800x525, 96-cycle HS, 2-line VS, negative polarity)
  - a region-decode function
- Sub-module vga_axis_counter, instantiated once for h and once for v:
  - parameters: active, front-porch, sync and back-porch lengths
  - inputs: inc
  - outputs: count, wrap, active, sync

## Test plan
- Small mode: H 8/2/2/2 (HT = 14), V 4/1/1/1 (VT = 7), LAT = 2, active-high syncs. Reset then release with en = 1 → req = 1 with (0,0) in cycle 0; VGA shows the pixel in cycle 3; frame_start high only in cycle 3; HS/VS low during reset.
- Free-run 3 frames → HS high for 2 cycles every 14; VS high for 14 cycles starting at line 5; frame_start every 98 cycles; line_start every 14 cycles.
- Pixel source returns R = x[3:0], G = y[3:0] after 2 cycles → every active output equals the request issued 3 cycles earlier; all blank outputs are 0.
- Drop pix_valid for one active pixel → that pixel outputs 0 and underflow goes to 1 and stays set. Pulse underflow_clr together with a new drop → underflow stays 1. Clear alone → 0.
- Drop en at line 2 → the rest of the frame displays normally; the next frame has req = 0 and colour 0 while syncs continue. Re-assert en mid-frame → display resumes at the following frame_start.
- Assert reset at h = 5, v = 3 → outputs at reset values within the same cycle; after release, restart at (0,0) with no stale pipeline pixels.
